// File: rtl/scrisc_pkg.sv
// Shared SCRISC-16 definitions used by the execute-stage multi-cycle unit:
// default datapath width, multiply/divide op codes and sequencer state encoding.
package scrisc_pkg;

  localparam int MD_WIDTH = 16;

  // op[1] selects divide, op[0] selects the "other" half (high word / remainder)
  typedef enum logic [1:0] {
    MD_MULL = 2'b00,
    MD_MULH = 2'b01,
    MD_DIVU = 2'b10,
    MD_REMU = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_RUN  = 2'b01,
    MD_DONE = 2'b10
  } md_state_e;

endpackage

// File: rtl/md_addsub.sv
// W-bit adder/subtractor built on a single carry chain: subtraction is
// x + ~y + 1, so the multiply add and the divide trial share one adder.
module md_addsub #(
  parameter int W = 17
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         sub,
  output logic [W-1:0] sum
);

  // Conditional invert plus carry-in gives x+y or x-y from the same adder
  assign sum = x + (y ^ {W{sub}}) + W'(sub);

endmodule

// File: rtl/muldiv_seq.sv
// Iterative unsigned multiply / restoring divide sequencer. One iteration per
// cycle for WIDTH cycles; busy stalls the pipeline, done pulses for one cycle.
module muldiv_seq
  import scrisc_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  md_state_e        state_q, state_d;
  md_op_e           op_q;
  logic [WIDTH-1:0] acc_q;     // product high word, or divide remainder
  logic [WIDTH-1:0] quo_q;     // product low word, or divide quotient
  logic [WIDTH-1:0] b_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] result_q;
  logic             dbz_q;

  logic             accept;
  logic             dbz_start;
  logic             last_iter;

  logic [WIDTH:0]   r_sh;
  logic [WIDTH:0]   as_x, as_y, as_sum;
  logic             as_sub;
  logic [WIDTH-1:0] acc_nx, quo_nx, result_nx;

  // A start is honoured whenever the sequencer is not mid-operation
  assign accept    = start && (state_q != MD_RUN);
  assign dbz_start = accept && op[1] && (b == '0);
  assign last_iter = (state_q == MD_RUN) && (cnt_q == LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    if (!rst_n) state_q <= MD_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; divide by zero bypasses RUN entirely
  always_comb begin
    // NOTE: default assigned first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      MD_IDLE, MD_DONE: begin
        if (start)                 state_d = dbz_start ? MD_DONE : MD_RUN;
        else if (state_q == MD_DONE) state_d = MD_IDLE;
      end
      MD_RUN:  if (cnt_q == LAST) state_d = MD_DONE;
      default: state_d = MD_IDLE;
    endcase
  end

  // Operand steering into the shared adder: trial subtract for divide,
  // conditional add of the multiplier for multiply
  always_comb begin
    r_sh   = {acc_q, quo_q[WIDTH-1]};
    as_sub = 1'b0;
    as_x   = {1'b0, acc_q};
    as_y   = '0;
    if (op_q[1]) begin
      as_sub = 1'b1;
      as_x   = r_sh;
      as_y   = {1'b0, b_q};
    end else if (quo_q[0]) begin
      as_y   = {1'b0, b_q};
    end
  end

  md_addsub #(.W(WIDTH + 1)) u_addsub (
    .x   (as_x),
    .y   (as_y),
    .sub (as_sub),
    .sum (as_sum)
  );

  // One iteration: restoring-divide step or shift-add-multiply step
  always_comb begin
    acc_nx = acc_q;
    quo_nx = quo_q;
    if (op_q[1]) begin
      // Trial MSB is the sign: a non-negative trial always fits in WIDTH bits
      if (!as_sum[WIDTH]) begin
        acc_nx = as_sum[WIDTH-1:0];
        quo_nx = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_nx = r_sh[WIDTH-1:0];
        quo_nx = {quo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_nx = as_sum[WIDTH:1];
      quo_nx = {as_sum[0], quo_q[WIDTH-1:1]};
    end
    // op[0] picks the high word / remainder, otherwise low word / quotient
    result_nx = op_q[0] ? acc_nx : quo_nx;
  end

  // Datapath registers, counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= MD_MULL;
      acc_q    <= '0;
      quo_q    <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else if (accept) begin
      op_q  <= md_op_e'(op);
      acc_q <= '0;
      quo_q <= a;
      b_q   <= b;
      cnt_q <= '0;
      if (dbz_start) begin
        result_q <= op[0] ? a : '1;
        dbz_q    <= 1'b1;
      end else begin
        result_q <= '0;
        dbz_q    <= 1'b0;
      end
    end else if (state_q == MD_RUN) begin
      acc_q <= acc_nx;
      quo_q <= quo_nx;
      cnt_q <= cnt_q + CW'(1);
      if (last_iter) result_q <= result_nx;
    end
  end

  assign busy        = (state_q == MD_RUN);
  assign done        = (state_q == MD_DONE);
  assign result      = result_q;
  assign div_by_zero = dbz_q;

endmodule
